// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus packing stage that sits after the bus breakout.
// The packed-word struct here is sized for the default geometry.
package bus_pkg;

  localparam int BUS_W     = 6;
  localparam int BUS_LANES = 4;
  localparam int BUS_CW    = $clog2(BUS_LANES + 1);

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILLING,
    FILL_FULL
  } fill_state_t;

  typedef struct packed {
    logic [BUS_W*BUS_LANES-1:0] data;
    logic [BUS_CW-1:0]          count;
    logic                       last;
  } bus_word_t;

endpackage

// File: rtl/bus_pack_slot.sv
// Single-entry valid/ready holding register. It accepts a new entry whenever it is
// empty or its current entry is leaving on the same edge, so back-to-back words see no bubble.
module bus_pack_slot
  import bus_pkg::*;
#(
  parameter int DW = $bits(bus_word_t)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/bus_packer.sv
// Packs LANES consecutive W-bit samples into one wide word, with flush to close partial
// words and a one-word output register so the next word can fill while the last one waits.
module bus_packer
  import bus_pkg::*;
#(
  parameter int W     = BUS_W,
  parameter int LANES = BUS_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [W*LANES-1:0]           out_data,
  output logic [$clog2(LANES+1)-1:0]   out_count,
  output logic                         out_last,
  input  logic                         out_ready
);

  localparam int CW = $clog2(LANES + 1);
  localparam int DW = W * LANES;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] count;
    logic          last;
  } word_t;

  fill_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] lanes_q;
  logic          last_q;

  logic          accept;
  logic          close;
  logic [CW-1:0] cnt_d;
  logic [DW-1:0] lanes_d;
  logic          slot_in_valid;
  logic          slot_in_ready;
  word_t         slot_in;
  word_t         slot_out;

  assign in_ready = rst && (state_q != FILL_FULL);
  assign accept   = in_valid && in_ready;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (cnt_q == CW'(k)) lanes_d[k*W +: W] = in_data;
      end
      cnt_d = cnt_q + CW'(1);
    end

    // cnt_d is non-zero exactly when the word already holds a sample or gains one now.
    close = (state_q != FILL_FULL) &&
            ((cnt_d == CW'(LANES)) || (flush && (cnt_d != '0)));

    slot_in_valid = (state_q == FILL_FULL) || close;
    if (state_q == FILL_FULL) slot_in = '{data: lanes_q, count: cnt_q, last: last_q};
    else                      slot_in = '{data: lanes_d, count: cnt_d, last: flush};
  end

  // NOTE: lane storage is reset and cleared on close because unused lanes of a flushed word must read 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL_EMPTY;
      cnt_q   <= '0;
      lanes_q <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL_FULL: begin
          if (slot_in_ready) begin
            state_q <= FILL_EMPTY;
            cnt_q   <= '0;
            lanes_q <= '0;
            last_q  <= 1'b0;
          end
        end
        default: begin
          if (close) begin
            if (slot_in_ready) begin
              state_q <= FILL_EMPTY;
              cnt_q   <= '0;
              lanes_q <= '0;
              last_q  <= 1'b0;
            end else begin
              state_q <= FILL_FULL;
              cnt_q   <= cnt_d;
              lanes_q <= lanes_d;
              last_q  <= flush;
            end
          end else if (accept) begin
            state_q <= FILLING;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
          end
        end
      endcase
    end
  end

  bus_pack_slot #(
    .DW($bits(word_t))
  ) u_out_slot (
    .clk         (clk),
    .rst_n       (rst),
    .in_valid_i  (slot_in_valid),
    .in_data_i   (slot_in),
    .in_ready_o  (slot_in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (slot_out),
    .out_ready_i (out_ready)
  );

  assign out_data  = slot_out.data;
  assign out_count = slot_out.count;
  assign out_last  = slot_out.last;

endmodule
